// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues credit-limited word fetches and queues in-order responses for decode.
// Optional feature macro IFU_MISALIGN_TRAP_EN adds id_fault and a HALT state for misaligned redirects.
module instr_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instrn,
    output logic [XLEN-1:0] id_pc
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    output logic            id_fault
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]     DEPTH_C    = (CW+1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

`ifdef IFU_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;
`else
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;
`endif

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [PW-1:0]   r_ifq_wptr;
    logic [PW-1:0]   r_ifq_rptr;

    logic [XLEN-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]     r_fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0] r_ifq        [FIFO_DEPTH];

    logic [CW:0]     w_credit_used;
    logic            w_req_fire;
    logic            w_rsp_fire;
    logic            w_rsp_keep;
    logic            w_pop;
    logic            w_fault_push;
    logic [CW-1:0]   w_out_next;

`ifdef IFU_MISALIGN_TRAP_EN
    logic            w_misalign;
    logic            r_fifo_fault [FIFO_DEPTH];
    assign w_misalign   = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign w_fault_push = w_misalign;
`else
    assign w_fault_push = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = S_RUN;
            default: w_state_next = r_state;
        endcase
`ifdef IFU_MISALIGN_TRAP_EN
        if (redirect_valid) begin
            w_state_next = w_misalign ? S_HALT : S_RUN;
        end
`endif
    end

    // Credits cover both buffered entries and fetches still in flight, so a response can always be pushed.
    assign w_credit_used  = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req_valid = (r_state == S_RUN) & ~redirect_valid & (w_credit_used < DEPTH_C);
    assign imem_req_addr  = r_pc;

    assign w_req_fire = imem_req_valid & imem_req_ready;
    assign w_rsp_fire = imem_rsp_valid & (r_outstanding != '0);
    assign w_rsp_keep = w_rsp_fire & (r_drop == '0) & ~redirect_valid;
    assign w_pop      = id_valid & id_ready & ~redirect_valid;
    assign w_out_next = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_fire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_ifq_wptr    <= '0;
            r_ifq_rptr    <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_req_fire) begin
                r_ifq_wptr <= r_ifq_wptr + PW'(1);
            end
            if (w_rsp_fire) begin
                r_ifq_rptr <= r_ifq_rptr + PW'(1);
            end
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path.
                r_pc   <= redirect_pc & ALIGN_MASK;
                r_drop <= r_outstanding - CW'(w_rsp_fire);
                r_rptr <= '0;
                if (w_fault_push) begin
                    r_count <= CW'(1);
                    r_wptr  <= PW'(1);
                end else begin
                    r_count <= '0;
                    r_wptr  <= '0;
                end
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + XLEN'(4);
                end
                if (w_rsp_fire && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (w_rsp_keep) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                r_count <= r_count + CW'(w_rsp_keep) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fault_push) begin
            r_fifo_pc[0]    <= redirect_pc;
            r_fifo_instr[0] <= 32'h0000_0013;
        end else if (w_rsp_keep) begin
            r_fifo_pc[r_wptr]    <= r_ifq[r_ifq_rptr];
            r_fifo_instr[r_wptr] <= imem_rsp_data;
        end
        if (w_req_fire) begin
            r_ifq[r_ifq_wptr] <= r_pc;
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (w_fault_push) begin
            r_fifo_fault[0] <= 1'b1;
        end else if (w_rsp_keep) begin
            r_fifo_fault[r_wptr] <= 1'b0;
        end
    end
    assign id_fault = id_valid & r_fifo_fault[r_rptr];
`endif

    assign id_valid  = (r_count != '0);
    assign id_instrn = id_valid ? r_fifo_instr[r_rptr] : 32'h0;
    assign id_pc     = id_valid ? r_fifo_pc[r_rptr] : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: queue-based fetch/delivery model plus directed scenarios.
// Builds with or without IFU_MISALIGN_TRAP_EN.
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instrn;
    logic [31:0] id_pc;
`ifdef IFU_MISALIGN_TRAP_EN
    logic        id_fault;
`endif

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instrn      (id_instrn),
`ifdef IFU_MISALIGN_TRAP_EN
        .id_fault       (id_fault),
`endif
        .id_pc          (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {logic [31:0] pc; logic [31:0] instr; logic fault;} ent_t;
    typedef struct {logic [31:0] addr; int epoch; int due;} mreq_t;

    int checks = 0;
    int errors = 0;

    ent_t  exp_q[$];
    mreq_t mem_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_ins[$];

    logic [31:0] m_pc;
    logic        m_running;
    logic        m_halt;
    int          m_epoch;
    int          cyc;
    int          mem_lat;
    logic        rsp_now;
    logic        exp_valid;
    logic        exp_req;
    logic        fire;
    logic        pop;
    mreq_t       me;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], 16'h0093};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
        end
    endtask

    function automatic logic [31:0] acc_at(input int i);
        return (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pc_at(input int i);
        return (i < del_pc.size()) ? del_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] ins_at(input int i);
        return (i < del_ins.size()) ? del_ins[i] : 32'hDEAD_BEEF;
    endfunction

    // Memory drives its response at +2 after negedge; the model compares and advances at +4.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            mem_q.delete();
            rsp_now = 1'b0;
        end else begin
            rsp_now = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        end
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_data(mem_q[0].addr) : 32'h0;
        #2;
        if (rst) begin
            chk("rst_id_valid", id_valid, 0);
            chk("rst_id_pc", id_pc, 0);
            chk("rst_id_instrn", id_instrn, 0);
            chk("rst_req_valid", imem_req_valid, 0);
`ifdef IFU_MISALIGN_TRAP_EN
            chk("rst_id_fault", id_fault, 0);
`endif
            exp_q.delete();
            m_pc = 32'h0; m_running = 1'b0; m_halt = 1'b0; m_epoch = 0; cyc = 0;
        end else begin
            exp_valid = (exp_q.size() != 0);
            chk("id_valid", id_valid, exp_valid);
            if (exp_valid) begin
                chk("id_pc", id_pc, exp_q[0].pc);
                chk("id_instrn", id_instrn, exp_q[0].instr);
`ifdef IFU_MISALIGN_TRAP_EN
                chk("id_fault", id_fault, exp_q[0].fault);
`endif
            end
            exp_req = m_running && !m_halt && !redirect_valid && ((exp_q.size() + mem_q.size()) < DEPTH);
            chk("req_valid", imem_req_valid, exp_req);
            if (exp_req) chk("req_addr", imem_req_addr, m_pc);

            if (imem_req_valid && imem_req_ready) acc_log.push_back(imem_req_addr);
            if (id_valid && id_ready && !redirect_valid) begin
                del_pc.push_back(id_pc);
                del_ins.push_back(id_instrn);
                $display("deliver pc=0x%08h instr=0x%08h", id_pc, id_instrn);
            end

            fire = exp_req && imem_req_ready;
            pop  = exp_valid && id_ready && !redirect_valid;
            if (pop) void'(exp_q.pop_front());
            if (rsp_now) begin
                me = mem_q.pop_front();
                if (me.epoch == m_epoch && !redirect_valid)
                    exp_q.push_back('{pc: me.addr, instr: mem_data(me.addr), fault: 1'b0});
            end
            if (fire) begin
                mem_q.push_back('{addr: m_pc, epoch: m_epoch, due: cyc + mem_lat});
                m_pc = m_pc + 32'd4;
            end
            if (redirect_valid) begin
                exp_q.delete();
                m_epoch++;
                m_pc = {redirect_pc[31:2], 2'b00};
                m_halt = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
                if (redirect_pc[1:0] != 2'b00) begin
                    exp_q.push_back('{pc: redirect_pc, instr: 32'h0000_0013, fault: 1'b1});
                    m_halt = 1'b1;
                end
`endif
            end
            m_running = 1'b1;
            cyc++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        acc_log.delete(); del_pc.delete(); del_ins.delete();
    endtask

    task automatic redir(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    logic found;

    initial begin
        rst = 1'b1; id_ready = 1'b1; imem_req_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0; mem_lat = 1;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        cycles(3);
        rst = 1'b0;
        clear_logs();

        // Sequential fetch from reset, 1-cycle memory
        cycles(12);
        chk("t1_acc0", acc_at(0), 32'h0);
        chk("t1_acc1", acc_at(1), 32'h4);
        chk("t1_acc2", acc_at(2), 32'h8);
        chk("t1_del0", pc_at(0), 32'h0);
        chk("t1_del1", pc_at(1), 32'h4);
        chk("t1_del2", pc_at(2), 32'h8);
        chk("t1_ins0", ins_at(0), 32'h0000_0093);
        chk("t1_ins2", ins_at(2), 32'h0008_0093);

        // Decode stall: only DEPTH fetches may be issued, then resume in order
        clear_logs();
        id_ready = 1'b0;
        redir(32'h200);
        cycles(10);
        chk("t2_acc_count", acc_log.size(), DEPTH);
        chk("t2_acc0", acc_at(0), 32'h200);
        chk("t2_acc1", acc_at(1), 32'h204);
        chk("t2_no_del", del_pc.size(), 0);
        id_ready = 1'b1;
        cycles(10);
        chk("t2_del0", pc_at(0), 32'h200);
        chk("t2_del1", pc_at(1), 32'h204);
        chk("t2_del2", pc_at(2), 32'h208);
        chk("t2_del3", pc_at(3), 32'h20C);

        // Redirect with two fetches outstanding
        mem_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); #3;
            if (mem_q.size() == 2) found = 1'b1;
        end
        chk("t3_two_outstanding", found, 1);
        clear_logs();
        redir(32'h100);
        cycles(20);
        chk("t3_acc0", acc_at(0), 32'h100);
        chk("t3_del0", pc_at(0), 32'h100);
        chk("t3_del1", pc_at(1), 32'h104);

        // Redirect coinciding with a response and a decode pop
        mem_lat = 1;
        cycles(4);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); #3;
            if (imem_rsp_valid && id_valid) found = 1'b1;
        end
        chk("t4_rsp_and_pop", found, 1);
        clear_logs();
        redir(32'h300);
        #3;
        chk("t4_fifo_empty", id_valid, 0);
        cycles(10);
        chk("t4_acc0", acc_at(0), 32'h300);
        chk("t4_del0", pc_at(0), 32'h300);

        // PC wrap at top of address space
        clear_logs();
        redir(32'hFFFF_FFFC);
        cycles(8);
        chk("t5_acc0", acc_at(0), 32'hFFFF_FFFC);
        chk("t5_acc1", acc_at(1), 32'h0000_0000);
        chk("t5_del0", pc_at(0), 32'hFFFF_FFFC);
        chk("t5_ins0", ins_at(0), 32'hFFFC_0093);
        chk("t5_del1", pc_at(1), 32'h0000_0000);

        // Misaligned redirect target
        clear_logs();
        redir(32'h102);
        cycles(8);
`ifdef IFU_MISALIGN_TRAP_EN
        chk("t6_no_fetch", acc_log.size(), 0);
        chk("t6_fault_pc", pc_at(0), 32'h102);
        chk("t6_fault_ins", ins_at(0), 32'h0000_0013);
        clear_logs();
        redir(32'h400);
        cycles(6);
        chk("t6_resume_acc0", acc_at(0), 32'h400);
`else
        chk("t6_acc0", acc_at(0), 32'h100);
        chk("t6_del0", pc_at(0), 32'h100);
        chk("t6_del1", pc_at(1), 32'h104);
`endif

        // Reset with fetches in flight
        mem_lat = 3;
        cycles(3);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        mem_lat = 1;
        clear_logs();
        cycles(8);
        chk("t7_acc0", acc_at(0), 32'h0);
        chk("t7_del0", pc_at(0), 32'h0);
        chk("t7_del1", pc_at(1), 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
